// File: rtl/bids22_pkg.sv
// Shared widths, command record and sequencer state encoding for the bids22 command path.
package bids22_pkg;
  localparam int OP_W   = 4;
  localparam int ERR_W  = 3;
  localparam int DATA_W = 32;
  localparam int CMD_W  = OP_W + DATA_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } seq_state_t;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] data;
  } cmd_t;
endpackage

// File: rtl/bids22_cmd_fifo.sv
// Command FIFO: DEPTH entries (power of 2), pointers wrap naturally, occupancy count 0..DEPTH.
module bids22_cmd_fifo
  import bids22_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     i_push,
  input  logic [CMD_W-1:0]         i_din,
  input  logic                     i_pop,
  output logic [CMD_W-1:0]         o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [CMD_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr, r_rd;
  logic [CW-1:0]    r_count;
  logic             w_wr, w_rd;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd];
  assign w_wr    = i_push && !o_full;
  assign w_rd    = i_pop && !o_empty;

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr] <= i_din;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) r_wr <= r_wr + 1'b1;
      if (w_rd) r_rd <= r_rd + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/bids22_cmd_seq.sv
// Command sequencer: queues host commands and issues them one at a time to the auction unit.
// Optional WAIT timeout enabled by defining BIDS22_SEQ_TIMEOUT_EN.
module bids22_cmd_seq
  import bids22_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [OP_W-1:0]        cmd_op,
  input  logic [DATA_W-1:0]      cmd_data,
  output logic                   C_start,
  output logic [OP_W-1:0]        C_op,
  output logic [DATA_W-1:0]      C_data,
  input  logic                   ready,
  input  logic [ERR_W-1:0]       err,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [OP_W-1:0]        rsp_op,
  output logic [ERR_W-1:0]       rsp_err,
  output logic                   rsp_timeout,
  output logic [$clog2(DEPTH):0] fifo_count
);
  seq_state_t        r_state;
  logic              r_c_start;
  logic [OP_W-1:0]   r_c_op;
  logic [DATA_W-1:0] r_c_data;
  logic              r_rsp_valid;
  logic [OP_W-1:0]   r_rsp_op;
  logic [ERR_W-1:0]  r_rsp_err;

  logic              w_full, w_empty, w_push, w_pop;
  logic [CMD_W-1:0]  w_head_raw;
  cmd_t              w_head, w_din;

  assign cmd_ready = !w_full;
  assign w_push    = cmd_valid && !w_full;
  // Pop only from IDLE, so at most one command is ever outstanding downstream.
  assign w_pop     = (r_state == S_IDLE) && !w_empty && ready;
  assign w_din     = '{op: cmd_op, data: cmd_data};
  assign w_head    = cmd_t'(w_head_raw);

  bids22_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (w_push),
    .i_din   (w_din),
    .i_pop   (w_pop),
    .o_head  (w_head_raw),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (fifo_count)
  );

`ifdef BIDS22_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] r_wcnt;
  logic          r_rsp_timeout;
  assign rsp_timeout = r_rsp_timeout;
`else
  assign rsp_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_c_start     <= 1'b0;
      r_c_op        <= '0;
      r_c_data      <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_op      <= '0;
      r_rsp_err     <= '0;
`ifdef BIDS22_SEQ_TIMEOUT_EN
      r_wcnt        <= '0;
      r_rsp_timeout <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_c_op    <= w_head.op;
            r_c_data  <= w_head.data;
            r_c_start <= 1'b1;
            r_state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_c_start <= 1'b0;
          r_state   <= S_WAIT;
`ifdef BIDS22_SEQ_TIMEOUT_EN
          r_wcnt    <= '0;
`endif
        end
        S_WAIT: begin
          if (ready) begin
            r_rsp_valid   <= 1'b1;
            r_rsp_op      <= r_c_op;
            r_rsp_err     <= err;
`ifdef BIDS22_SEQ_TIMEOUT_EN
            r_rsp_timeout <= 1'b0;
`endif
            r_state       <= S_RESP;
          end
`ifdef BIDS22_SEQ_TIMEOUT_EN
          else if (r_wcnt == TW'(TIMEOUT - 1)) begin
            r_rsp_valid   <= 1'b1;
            r_rsp_op      <= r_c_op;
            r_rsp_err     <= '0;
            r_rsp_timeout <= 1'b1;
            r_state       <= S_RESP;
          end else begin
            r_wcnt <= r_wcnt + 1'b1;
          end
`endif
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign C_start   = r_c_start;
  assign C_op      = r_c_op;
  assign C_data    = r_c_data;
  assign rsp_valid = r_rsp_valid;
  assign rsp_op    = r_rsp_op;
  assign rsp_err   = r_rsp_err;
endmodule

// File: tb/tb_bids22_cmd_seq.sv
// Self-checking bench for bids22_cmd_seq: cycle vector table plus directed multi-cycle sequences.
module tb_bids22_cmd_seq;
`ifdef BIDS22_SEQ_TIMEOUT_EN
  localparam int TB_TO  = 8;
  localparam int B_WAIT = 5;
`else
  localparam int TB_TO  = 255;
  localparam int B_WAIT = 10;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid, cmd_ready;
  logic [3:0]  cmd_op;
  logic [31:0] cmd_data;
  logic        C_start;
  logic [3:0]  C_op;
  logic [31:0] C_data;
  logic        ready;
  logic [2:0]  err;
  logic        rsp_valid, rsp_ready;
  logic [3:0]  rsp_op;
  logic [2:0]  rsp_err;
  logic        rsp_timeout;
  logic [2:0]  fifo_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bids22_cmd_seq #(.DEPTH(4), .TIMEOUT(TB_TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .C_start(C_start), .C_op(C_op), .C_data(C_data),
    .ready(ready), .err(err),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_op(rsp_op), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout), .fifo_count(fifo_count)
  );

  typedef struct {
    logic        cv;
    logic [3:0]  op;
    logic [31:0] data;
    logic        rdy;
    logic [2:0]  er;
    logic        rr;
    logic        e_cr;
    logic        e_cs;
    logic [3:0]  e_cop;
    logic [31:0] e_cdata;
    logic        e_rv;
    logic [3:0]  e_rop;
    logic [2:0]  e_rerr;
    logic [2:0]  e_cnt;
  } vec_t;

  vec_t tbl [20];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0;
    ready = 1'b0; err = '0; rsp_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic push(input logic [3:0] op, input logic [31:0] d);
    cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
    step();
    cmd_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, seen;
    //            cv   op    data          rdy  er    rr  | cr   cs   cop   cdata         rv   rop   rerr  cnt
    tbl[0]  = '{1'b1,4'h3,32'd100,       1'b1,3'd0,1'b0, 1'b1,1'b0,4'h0,32'd0,         1'b0,4'h0,3'd0,3'd1};
    tbl[1]  = '{1'b0,4'h0,32'd0,         1'b1,3'd0,1'b0, 1'b1,1'b1,4'h3,32'd100,       1'b0,4'h0,3'd0,3'd0};
    tbl[2]  = '{1'b0,4'h0,32'd0,         1'b1,3'd0,1'b0, 1'b1,1'b0,4'h3,32'd100,       1'b0,4'h0,3'd0,3'd0};
    tbl[3]  = '{1'b0,4'h0,32'd0,         1'b1,3'd0,1'b0, 1'b1,1'b0,4'h3,32'd100,       1'b1,4'h3,3'd0,3'd0};
    tbl[4]  = '{1'b0,4'h0,32'd0,         1'b1,3'd0,1'b0, 1'b1,1'b0,4'h3,32'd100,       1'b1,4'h3,3'd0,3'd0};
    tbl[5]  = '{1'b0,4'h0,32'd0,         1'b1,3'd0,1'b1, 1'b1,1'b0,4'h3,32'd100,       1'b0,4'h0,3'd0,3'd0};
    tbl[6]  = '{1'b1,4'h5,32'hDEAD_BEEF, 1'b1,3'd5,1'b0, 1'b1,1'b0,4'h3,32'd100,       1'b0,4'h0,3'd0,3'd1};
    tbl[7]  = '{1'b0,4'h0,32'd0,         1'b1,3'd5,1'b0, 1'b1,1'b1,4'h5,32'hDEAD_BEEF, 1'b0,4'h0,3'd0,3'd0};
    tbl[8]  = '{1'b0,4'h0,32'd0,         1'b0,3'd5,1'b0, 1'b1,1'b0,4'h5,32'hDEAD_BEEF, 1'b0,4'h0,3'd0,3'd0};
    tbl[9]  = '{1'b0,4'h0,32'd0,         1'b1,3'd5,1'b0, 1'b1,1'b0,4'h5,32'hDEAD_BEEF, 1'b1,4'h5,3'd5,3'd0};
    tbl[10] = '{1'b0,4'h0,32'd0,         1'b1,3'd0,1'b1, 1'b1,1'b0,4'h5,32'hDEAD_BEEF, 1'b0,4'h0,3'd0,3'd0};
    tbl[11] = '{1'b1,4'h1,32'd1,         1'b0,3'd0,1'b0, 1'b1,1'b0,4'h5,32'hDEAD_BEEF, 1'b0,4'h0,3'd0,3'd1};
    tbl[12] = '{1'b1,4'h2,32'd2,         1'b1,3'd0,1'b0, 1'b1,1'b1,4'h1,32'd1,         1'b0,4'h0,3'd0,3'd1};
    tbl[13] = '{1'b0,4'h0,32'd0,         1'b1,3'd0,1'b0, 1'b1,1'b0,4'h1,32'd1,         1'b0,4'h0,3'd0,3'd1};
    tbl[14] = '{1'b0,4'h0,32'd0,         1'b1,3'd0,1'b0, 1'b1,1'b0,4'h1,32'd1,         1'b1,4'h1,3'd0,3'd1};
    tbl[15] = '{1'b0,4'h0,32'd0,         1'b1,3'd0,1'b1, 1'b1,1'b0,4'h1,32'd1,         1'b0,4'h0,3'd0,3'd1};
    tbl[16] = '{1'b0,4'h0,32'd0,         1'b1,3'd0,1'b0, 1'b1,1'b1,4'h2,32'd2,         1'b0,4'h0,3'd0,3'd0};
    tbl[17] = '{1'b0,4'h0,32'd0,         1'b1,3'd0,1'b0, 1'b1,1'b0,4'h2,32'd2,         1'b0,4'h0,3'd0,3'd0};
    tbl[18] = '{1'b0,4'h0,32'd0,         1'b1,3'd3,1'b0, 1'b1,1'b0,4'h2,32'd2,         1'b1,4'h2,3'd3,3'd0};
    tbl[19] = '{1'b0,4'h0,32'd0,         1'b1,3'd0,1'b1, 1'b1,1'b0,4'h2,32'd2,         1'b0,4'h0,3'd0,3'd0};

    // Reset state
    do_reset();
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_C_start", C_start, 0);
    chk("rst_C_op", C_op, 0);
    chk("rst_C_data", C_data, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_op", rsp_op, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rsp_timeout", rsp_timeout, 0);
    chk("rst_fifo_count", fifo_count, 0);

    // Cycle vector table
    for (int i = 0; i < 20; i++) begin
      cmd_valid = tbl[i].cv; cmd_op = tbl[i].op; cmd_data = tbl[i].data;
      ready = tbl[i].rdy; err = tbl[i].er; rsp_ready = tbl[i].rr;
      step();
      chk($sformatf("v%0d_cmd_ready", i), cmd_ready, tbl[i].e_cr);
      chk($sformatf("v%0d_C_start", i), C_start, tbl[i].e_cs);
      chk($sformatf("v%0d_C_op", i), C_op, tbl[i].e_cop);
      chk($sformatf("v%0d_C_data", i), C_data, tbl[i].e_cdata);
      chk($sformatf("v%0d_rsp_valid", i), rsp_valid, tbl[i].e_rv);
      chk($sformatf("v%0d_fifo_count", i), fifo_count, tbl[i].e_cnt);
      if (tbl[i].e_rv) begin
        chk($sformatf("v%0d_rsp_op", i), rsp_op, tbl[i].e_rop);
        chk($sformatf("v%0d_rsp_err", i), rsp_err, tbl[i].e_rerr);
        chk($sformatf("v%0d_rsp_timeout", i), rsp_timeout, 0);
      end
    end

    // Fill past full, then drain in push order
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cmd_valid = 1'b1; cmd_op = 4'(i + 1); cmd_data = 32'h100 + i;
      step();
      if (i == 3) chk("full_cmd_ready", cmd_ready, 0);
    end
    cmd_valid = 1'b0;
    chk("full_count", fifo_count, 4);
    chk("full_cmd_ready_after", cmd_ready, 0);
    ready = 1'b1; rsp_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 60; c++) begin
      step();
      if (C_start) begin
        if (n < 4) begin
          chk($sformatf("drain%0d_op", n), C_op, n + 1);
          chk($sformatf("drain%0d_data", n), C_data, 32'h100 + n);
        end
        n++;
      end
    end
    chk("drain_issue_count", n, 4);
    chk("drain_final_count", fifo_count, 0);

    // Long wait for ready, then error code
    do_reset();
    ready = 1'b1;
    push(4'h7, 32'd77);
    step();
    chk("lw_C_start", C_start, 1);
    ready = 1'b0;
    step();
    seen = 0;
    for (int c = 0; c < B_WAIT; c++) begin
      step();
      if (rsp_valid) seen++;
    end
    chk("lw_no_early_rsp", seen, 0);
    ready = 1'b1; err = 3'b010;
    step();
    chk("lw_rsp_valid", rsp_valid, 1);
    chk("lw_rsp_op", rsp_op, 7);
    chk("lw_rsp_err", rsp_err, 2);
    chk("lw_rsp_timeout", rsp_timeout, 0);

    // Response back-pressure with two commands queued
    do_reset();
    push(4'h8, 32'd8);
    push(4'h9, 32'd9);
    push(4'hA, 32'd10);
    ready = 1'b1;
    step();
    chk("bp_C_start", C_start, 1);
    chk("bp_C_op", C_op, 8);
    chk("bp_count", fifo_count, 2);
    step();
    step();
    chk("bp_rsp_valid", rsp_valid, 1);
    for (int c = 0; c < 5; c++) begin
      step();
      chk($sformatf("bp%0d_rsp_valid", c), rsp_valid, 1);
      chk($sformatf("bp%0d_rsp_op", c), rsp_op, 8);
      chk($sformatf("bp%0d_no_start", c), C_start, 0);
      chk($sformatf("bp%0d_count", c), fifo_count, 2);
    end
    rsp_ready = 1'b1;
    step();
    chk("bp_consumed", rsp_valid, 0);
    rsp_ready = 1'b0;
    step();
    chk("bp_next_start", C_start, 1);
    chk("bp_next_op", C_op, 9);
    chk("bp_next_count", fifo_count, 1);

    // Reset during WAIT with three queued
    do_reset();
    for (int i = 0; i < 4; i++) push(4'(11 + i), 32'(11 + i));
    ready = 1'b1;
    step();
    chk("mr_C_start", C_start, 1);
    ready = 1'b0;
    step();
    chk("mr_count", fifo_count, 3);
    #2 reset_n = 1'b0;
    #1;
    chk("mr_C_start0", C_start, 0);
    chk("mr_C_op0", C_op, 0);
    chk("mr_C_data0", C_data, 0);
    chk("mr_rsp_valid0", rsp_valid, 0);
    chk("mr_rsp_op0", rsp_op, 0);
    chk("mr_rsp_err0", rsp_err, 0);
    chk("mr_rsp_timeout0", rsp_timeout, 0);
    chk("mr_count0", fifo_count, 0);
    chk("mr_cmd_ready1", cmd_ready, 1);
    @(posedge clk);
    #1 reset_n = 1'b1;
    ready = 1'b1; rsp_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (C_start || rsp_valid) seen++;
    end
    chk("mr_no_activity", seen, 0);

`ifdef BIDS22_SEQ_TIMEOUT_EN
    // Timeout after TB_TO WAIT cycles
    do_reset();
    ready = 1'b1; err = 3'b111;
    push(4'h6, 32'd6);
    step();
    chk("to_C_start", C_start, 1);
    ready = 1'b0;
    step();
    seen = 0;
    for (int c = 0; c < TB_TO - 1; c++) begin
      step();
      if (rsp_valid) seen++;
    end
    chk("to_no_early_rsp", seen, 0);
    step();
    chk("to_rsp_valid", rsp_valid, 1);
    chk("to_rsp_timeout", rsp_timeout, 1);
    chk("to_rsp_err", rsp_err, 0);
    chk("to_rsp_op", rsp_op, 6);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
